fir_mmio_rsp: RTL and testbench



---
 rtl/fir_mmio_rsp.sv | 152 +++++++++++++++
 tb/tb_fir_mmio_rsp.sv | 321 ++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fir_mmio_rsp.sv
// CCI-P type subset used by the FIR AFU, and the MMIO read responder that returns
// AFU header, control/buffer registers and FIR status on c2 two cycles after each c0 read.
package fir_ccip_pkg;
  typedef logic [8:0] t_ccip_tid;

  typedef struct packed {
    logic [15:0] address;
    logic [1:0]  length;
    logic        rsvd0;
    t_ccip_tid   tid;
  } t_ccip_c0_ReqMmioHdr;

  typedef struct packed {
    t_ccip_c0_ReqMmioHdr hdr;
    logic [511:0]        data;
    logic                rspValid;
    logic                mmioRdValid;
    logic                mmioWrValid;
  } t_if_ccip_c0_Rx;

  typedef struct packed {
    t_ccip_tid tid;
  } t_ccip_c2_RspMmioHdr;

  typedef struct packed {
    t_ccip_c2_RspMmioHdr hdr;
    logic                mmioRdValid;
    logic [63:0]         data;
  } t_if_ccip_c2_Tx;

  typedef struct packed {
    logic [63:0] address;
    logic [31:0] size;
  } t_hc_buffer;
endpackage

module fir_mmio_rsp
  import fir_ccip_pkg::*;
#(
  parameter logic [63:0] AFU_ID_L       = 64'h0,
  parameter logic [63:0] AFU_ID_H       = 64'h0,
  parameter int          HC_BUFFER_SIZE = 3
) (
  input  logic           clk,
  input  logic           reset_n,
  input  t_if_ccip_c0_Rx rx_mmio_channel,
  output t_if_ccip_c2_Tx tx_mmio_channel,
  input  logic [31:0]    dsm_base,
  input  logic [31:0]    control,
  input  t_hc_buffer     buffers [HC_BUFFER_SIZE],
  input  logic           fir_busy,
  input  logic           fir_done
);

  localparam logic [63:0] DFH_VALUE = 64'h1000_0100_0000_0000;

  // Register map in qword (8-byte) units.
  localparam logic [14:0] QW_DFH      = 15'h00;
  localparam logic [14:0] QW_AFU_ID_L = 15'h01;
  localparam logic [14:0] QW_AFU_ID_H = 15'h02;
  localparam logic [14:0] QW_DSM_BASE = 15'h22;
  localparam logic [14:0] QW_CONTROL  = 15'h23;
  localparam logic [14:0] QW_STATUS   = 15'h30;
  localparam logic [14:0] QW_RD_COUNT = 15'h31;
  localparam int          QW_BUF_BASE = 'h24;

  logic        a_valid;
  logic [8:0]  a_tid;
  logic [15:0] a_address;
  logic [1:0]  a_length;

  logic        b_valid;
  logic [8:0]  b_tid;
  logic [63:0] b_data;

  logic [31:0] rd_count;

  logic [14:0] qw;
  logic [63:0] reg_value;
  logic [63:0] rsp_data;

  assign qw = a_address[15:1];

  always_comb begin
    reg_value = 64'h0;
    // Everything at DWORD 'h100 and above is unmapped.
    if (a_address[15:8] == 8'h0) begin
      case (qw)
        QW_DFH:      reg_value = DFH_VALUE;
        QW_AFU_ID_L: reg_value = AFU_ID_L;
        QW_AFU_ID_H: reg_value = AFU_ID_H;
        QW_DSM_BASE: reg_value = {32'h0, dsm_base};
        QW_CONTROL:  reg_value = {32'h0, control};
        QW_STATUS:   reg_value = {62'h0, fir_busy, fir_done};
        QW_RD_COUNT: reg_value = {32'h0, rd_count};
        default:     reg_value = 64'h0;
      endcase
      for (int i = 0; i < HC_BUFFER_SIZE; i++) begin
        if (32'(qw) == 32'(QW_BUF_BASE + 2 * i))
          reg_value = buffers[i].address;
        if (32'(qw) == 32'(QW_BUF_BASE + 2 * i + 1))
          reg_value = {32'h0, buffers[i].size};
      end
    end
  end

  always_comb begin
    case (a_length)
      2'd0:    rsp_data = {32'h0, a_address[0] ? reg_value[63:32] : reg_value[31:0]};
      2'd1:    rsp_data = a_address[0] ? 64'h0 : reg_value;
      default: rsp_data = 64'h0;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset_n) begin
      a_valid   <= 1'b0;
      a_tid     <= 9'h0;
      a_address <= 16'h0;
      a_length  <= 2'h0;
      b_valid   <= 1'b0;
      b_tid     <= 9'h0;
      b_data    <= 64'h0;
      rd_count  <= 32'h0;
    end else begin
      a_valid <= rx_mmio_channel.mmioRdValid;
      if (rx_mmio_channel.mmioRdValid) begin
        a_tid     <= rx_mmio_channel.hdr.tid;
        a_address <= rx_mmio_channel.hdr.address;
        a_length  <= rx_mmio_channel.hdr.length;
      end
      b_valid <= a_valid;
      b_tid   <= a_valid ? a_tid : 9'h0;
      b_data  <= a_valid ? rsp_data : 64'h0;
      if (a_valid)
        rd_count <= rd_count + 32'd1;
    end
  end

  always_comb begin
    tx_mmio_channel             = '0;
    tx_mmio_channel.hdr.tid     = b_tid;
    tx_mmio_channel.mmioRdValid = b_valid;
    tx_mmio_channel.data        = b_data;
  end

  // Writes, memory responses and c0 payload are handled elsewhere.
  logic unused_rx;
  assign unused_rx = ^{rx_mmio_channel.data, rx_mmio_channel.rspValid,
                       rx_mmio_channel.mmioWrValid, rx_mmio_channel.hdr.rsvd0};

endmodule

// File: tb/tb_fir_mmio_rsp.sv
// Bench for fir_mmio_rsp: fixed vector table, hand-written corner sequences and
// randomized traffic checked against a register-map model with cycle-exact timing.
module tb_fir_mmio_rsp;
  import fir_ccip_pkg::*;

  localparam logic [63:0] ID_L = 64'h0123_4567_89AB_CDEF;
  localparam logic [63:0] ID_H = 64'hFEDC_BA98_7654_3210;
  localparam int          NBUF = 3;
  localparam logic [63:0] DFH  = 64'h1000_0100_0000_0000;

  logic           clk = 1'b0;
  logic           reset_n;
  t_if_ccip_c0_Rx rx;
  t_if_ccip_c2_Tx tx;
  logic [31:0]    dsm_base;
  logic [31:0]    control;
  t_hc_buffer     buffers [NBUF];
  logic           fir_busy;
  logic           fir_done;

  always #5 clk = ~clk;

  fir_mmio_rsp #(
    .AFU_ID_L(ID_L),
    .AFU_ID_H(ID_H),
    .HC_BUFFER_SIZE(NBUF)
  ) dut (
    .clk(clk),
    .reset_n(reset_n),
    .rx_mmio_channel(rx),
    .tx_mmio_channel(tx),
    .dsm_base(dsm_base),
    .control(control),
    .buffers(buffers),
    .fir_busy(fir_busy),
    .fir_done(fir_done)
  );

  int checks = 0;
  int failures = 0;
  int cyc = 0;
  bit mon_on = 1'b0;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          due;
  } exp_t;

  typedef struct {
    logic [8:0]  tid;
    logic [63:0] data;
    int          at;
  } got_t;

  typedef struct {
    logic [15:0] dw;
    logic [1:0]  len;
    logic [8:0]  tid;
    logic [63:0] exp;
  } vec_t;

  exp_t exp_q[$];
  got_t got_q[$];

  logic        pend = 1'b0;
  logic [15:0] pend_addr;
  logic [1:0]  pend_len;
  logic [8:0]  pend_tid;
  logic [31:0] model_count = 32'h0;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h (t=%0t)", name, act, req, $time);
    end
  endtask

  // Register map computed from byte addresses, then the access-size rules applied.
  function automatic logic [63:0] ref_read(input logic [15:0] dw, input logic [1:0] len);
    logic [63:0] r;
    int qbyte;
    int idx;
    qbyte = int'(dw) * 4;
    qbyte = qbyte - (qbyte % 8);
    r = 64'h0;
    if (qbyte == 0) r = DFH;
    else if (qbyte == 'h008) r = ID_L;
    else if (qbyte == 'h010) r = ID_H;
    else if (qbyte == 'h110) r = {32'h0, dsm_base};
    else if (qbyte == 'h118) r = {32'h0, control};
    else if (qbyte >= 'h120 && qbyte < 'h120 + 16 * NBUF) begin
      idx = (qbyte - 'h120) / 16;
      if ((qbyte - 'h120) % 16 == 0) r = buffers[idx].address;
      else r = {32'h0, buffers[idx].size};
    end
    else if (qbyte == 'h180) r = {62'h0, fir_busy, fir_done};
    else if (qbyte == 'h188) r = {32'h0, model_count};
    if (len == 2'd1) return dw[0] ? 64'h0 : r;
    if (len == 2'd0) return {32'h0, dw[0] ? r[63:32] : r[31:0]};
    return 64'h0;
  endfunction

  always @(posedge clk) begin
    cyc++;
    if (!reset_n) begin
      pend = 1'b0;
      exp_q.delete();
      model_count = 32'h0;
    end else begin
      pend      = rx.mmioRdValid;
      pend_addr = rx.hdr.address;
      pend_len  = rx.hdr.length;
      pend_tid  = rx.hdr.tid;
    end
  end

  // Mid-cycle: snapshot the register ports for the request now in stage A, then check tx.
  always @(negedge clk) begin
    exp_t e;
    got_t g;
    logic due_ok;
    if (pend) begin
      e.tid  = pend_tid;
      e.data = ref_read(pend_addr, pend_len);
      e.due  = cyc + 1;
      exp_q.push_back(e);
      model_count = model_count + 32'd1;
      pend = 1'b0;
    end
    if (mon_on) begin
      if (tx.mmioRdValid === 1'b1) begin
        g.tid = tx.hdr.tid;
        g.data = tx.data;
        g.at = cyc;
        got_q.push_back(g);
        due_ok = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        check("rsp_expected_now", 64'(due_ok), 64'h1);
        if (due_ok) begin
          check("rsp_tid", 64'(tx.hdr.tid), 64'(exp_q[0].tid));
          check("rsp_data", tx.data, exp_q[0].data);
          exp_q.pop_front();
        end
      end else begin
        due_ok = (exp_q.size() != 0) && (exp_q[0].due == cyc);
        check("rsp_missing", 64'(due_ok), 64'h0);
        if (due_ok) exp_q.pop_front();
        check("idle_valid", 64'(tx.mmioRdValid), 64'h0);
        check("idle_data", tx.data, 64'h0);
        check("idle_tid", 64'(tx.hdr.tid), 64'h0);
      end
    end
  end

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic ticks(input int n);
    for (int k = 0; k < n; k++) tick();
  endtask

  task automatic send(input logic [15:0] dw, input logic [1:0] len, input logic [8:0] tid);
    rx = '0;
    rx.mmioRdValid = 1'b1;
    rx.hdr.address = dw;
    rx.hdr.length = len;
    rx.hdr.tid = tid;
    tick();
    rx = '0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  vec_t vt[16];
  logic [15:0] hot_dw[18];

  initial begin
    int c0;
    reset_n = 1'b0;
    rx = '0;
    dsm_base = 32'h1234_5678;
    control = 32'hCAFE_F00D;
    buffers[0] = '{address: 64'h1111_2222_3333_4444, size: 32'h10};
    buffers[1] = '{address: 64'h5555_6666_7777_8888, size: 32'h20};
    buffers[2] = '{address: 64'hDEAD_BEEF_0000_1000, size: 32'h400};
    fir_busy = 1'b0;
    fir_done = 1'b0;

    vt[0]  = '{16'h000, 2'd1, 9'h05, DFH};
    vt[1]  = '{16'h002, 2'd1, 9'h06, ID_L};
    vt[2]  = '{16'h004, 2'd1, 9'h07, ID_H};
    vt[3]  = '{16'h006, 2'd1, 9'h08, 64'h0};
    vt[4]  = '{16'h008, 2'd1, 9'h09, 64'h0};
    vt[5]  = '{16'h050, 2'd1, 9'h0A, 64'hDEAD_BEEF_0000_1000};
    vt[6]  = '{16'h052, 2'd1, 9'h0B, 64'h400};
    vt[7]  = '{16'h051, 2'd0, 9'h0C, 64'hDEAD_BEEF};
    vt[8]  = '{16'h054, 2'd1, 9'h0D, 64'h0};
    vt[9]  = '{16'h100, 2'd1, 9'h0E, 64'h0};
    vt[10] = '{16'h045, 2'd1, 9'h0F, 64'h0};
    vt[11] = '{16'h044, 2'd1, 9'h10, 64'h1234_5678};
    vt[12] = '{16'h046, 2'd1, 9'h1FF, 64'hCAFE_F00D};
    vt[13] = '{16'h001, 2'd0, 9'h12, 64'h1000_0100};
    vt[14] = '{16'h048, 2'd1, 9'h13, 64'h1111_2222_3333_4444};
    vt[15] = '{16'h04E, 2'd0, 9'h14, 64'h20};

    hot_dw = '{16'h000, 16'h002, 16'h004, 16'h006, 16'h008, 16'h044, 16'h046, 16'h048,
               16'h04A, 16'h04C, 16'h04E, 16'h050, 16'h052, 16'h054, 16'h056, 16'h060,
               16'h062, 16'h100};

    tick();
    mon_on = 1'b1;
    ticks(2);
    check("reset_valid", 64'(tx.mmioRdValid), 64'h0);
    check("reset_data", tx.data, 64'h0);
    check("reset_tid", 64'(tx.hdr.tid), 64'h0);
    reset_n = 1'b1;

    // Back-to-back RD_COUNT reads straight after reset.
    got_q.delete();
    send(16'h062, 2'd1, 9'd1);
    c0 = cyc;
    send(16'h062, 2'd1, 9'd2);
    send(16'h062, 2'd1, 9'd3);
    send(16'h062, 2'd1, 9'd4);
    ticks(4);
    check("b2b_count", 64'(got_q.size()), 64'd4);
    for (int i = 0; i < got_q.size() && i < 4; i++) begin
      check("b2b_tid", 64'(got_q[i].tid), 64'(i + 1));
      check("b2b_data", got_q[i].data, 64'(i));
      check("b2b_cycle", 64'(got_q[i].at), 64'(c0 + 1 + i));
    end

    for (int v = 0; v < 16; v++) begin
      got_q.delete();
      send(vt[v].dw, vt[v].len, vt[v].tid);
      ticks(3);
      check("tbl_count", 64'(got_q.size()), 64'd1);
      if (got_q.size() >= 1) begin
        check("tbl_tid", 64'(got_q[0].tid), 64'(vt[v].tid));
        check("tbl_data", got_q[0].data, vt[v].exp);
      end
    end

    fir_busy = 1'b1; fir_done = 1'b0;
    got_q.delete();
    send(16'h060, 2'd1, 9'h21);
    ticks(3);
    fir_busy = 1'b0; fir_done = 1'b1;
    send(16'h060, 2'd1, 9'h22);
    ticks(3);
    check("status_count", 64'(got_q.size()), 64'd2);
    if (got_q.size() == 2) begin
      check("status_busy", got_q[0].data, 64'h2);
      check("status_done", got_q[1].data, 64'h1);
    end

    // Snapshot: value in the stage A cycle wins; later changes are ignored.
    got_q.delete();
    control = 32'h0000_0001;
    send(16'h046, 2'd1, 9'h31);
    control = 32'h0000_0002;
    tick();
    control = 32'h0000_0003;
    ticks(3);
    check("snap_count", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check("snap_data", got_q[0].data, 64'h2);

    // Reset while a read is in flight, plus a read presented during reset.
    got_q.delete();
    send(16'h002, 2'd1, 9'h41);
    reset_n = 1'b0;
    rx.mmioRdValid = 1'b1;
    rx.hdr.address = 16'h000;
    rx.hdr.length = 2'd1;
    rx.hdr.tid = 9'h42;
    tick();
    rx = '0;
    reset_n = 1'b1;
    ticks(4);
    check("rst_flight_none", 64'(got_q.size()), 64'd0);
    send(16'h062, 2'd1, 9'h43);
    ticks(3);
    check("rst_count_rsp", 64'(got_q.size()), 64'd1);
    if (got_q.size() == 1) check("rst_count_zero", got_q[0].data, 64'h0);

    // Randomized traffic; the monitor compares every response against the model.
    for (int n = 0; n < 600; n++) begin
      dsm_base = $urandom;
      if ($urandom % 2 == 0) control = $urandom;
      buffers[$urandom % NBUF] = '{address: {$urandom, $urandom}, size: $urandom};
      fir_busy = 1'($urandom);
      fir_done = 1'($urandom);
      rx = '0;
      rx.data = {16{$urandom}};
      rx.rspValid = 1'($urandom);
      rx.mmioWrValid = 1'($urandom);
      rx.mmioRdValid = ($urandom % 4) != 0;
      if ($urandom % 4 == 0) rx.hdr.address = 16'($urandom);
      else rx.hdr.address = hot_dw[$urandom % 18] + 16'($urandom % 2);
      rx.hdr.length = 2'($urandom % 2);
      rx.hdr.tid = 9'($urandom);
      reset_n = ($urandom % 64) != 0;
      tick();
    end
    rx = '0;
    reset_n = 1'b1;
    ticks(4);
    check("drain_empty", 64'(exp_q.size()), 64'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
